// File: rtl/alu_sequencer.sv
// alu_sequencer: registers ALU operands, collects results into a show-ahead FIFO.
// Optional zero/negative result flags are enabled with `define ALU_SEQ_FLAGS_EN.
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic [3:0] rsp_sel,
`ifdef ALU_SEQ_FLAGS_EN
    output logic       rsp_zero,
    output logic       rsp_neg,
`endif
    output logic [7:0] ops_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

`ifdef ALU_SEQ_FLAGS_EN
    localparam int EW = 14;
`else
    localparam int EW = 12;
`endif

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wdata;
    logic [EW-1:0] head;
    logic          accept;
    logic          push;
    logic          pop;

    assign cmd_ready = (state == IDLE) && (count < CNT_FULL);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == DRIVE);
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

`ifdef ALU_SEQ_FLAGS_EN
    assign wdata = {(alu_y == 8'h00), alu_y[7], alu_sel, alu_y};
`else
    assign wdata = {alu_sel, alu_y};
`endif

    assign head    = mem[rptr];
    assign rsp_y   = rsp_valid ? head[7:0] : 8'h00;
    assign rsp_sel = rsp_valid ? head[11:8] : 4'h0;

`ifdef ALU_SEQ_FLAGS_EN
    assign rsp_zero = rsp_valid && head[13];
    assign rsp_neg  = rsp_valid && head[12];
`endif

    // Storage needs no reset: count gates everything that is visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            alu_a    <= 4'h0;
            alu_b    <= 4'h0;
            alu_sel  <= 4'h0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ops_done <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a   <= cmd_a;
                        alu_b   <= cmd_b;
                        alu_sel <= cmd_sel;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    wptr     <= wptr + AW'(1);
                    ops_done <= ops_done + 8'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                rptr <= rptr + AW'(1);
            end

            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural ALU.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic [3:0] rsp_sel;
    logic [7:0] ops_done;
`ifdef ALU_SEQ_FLAGS_EN
    logic       rsp_zero;
    logic       rsp_neg;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_sel   (rsp_sel),
`ifdef ALU_SEQ_FLAGS_EN
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
`endif
        .ops_done  (ops_done)
    );

    // Stand-in for the 4-bit ALU: operands zero-extended, 8-bit signed result.
    always_comb begin
        alu_y = 8'h00;
        if (alu_sel[3]) begin
            case (alu_sel[2:0])
                3'b010:  alu_y = {4'h0, alu_a & alu_b};
                3'b011:  alu_y = {4'h0, alu_a | alu_b};
                3'b100:  alu_y = {4'h0, alu_a ^ alu_b};
                default: alu_y = 8'h00;
            endcase
        end else begin
            case (alu_sel[2:0])
                3'b110:  alu_y = {4'h0, alu_a} + {4'h0, alu_b};
                3'b111:  alu_y = {4'h0, alu_a} - {4'h0, alu_b};
                default: alu_y = {4'h0, alu_a};
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Present a command and return just after the accepting edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] sel);
        int w;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        check("issue_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_alu"}, {20'h0, alu_a, alu_b, alu_sel}, 32'h0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_y"}, 32'(rsp_y), 32'h00);
        check({tag, "_sel"}, 32'(rsp_sel), 32'h0);
        check({tag, "_ops"}, 32'(ops_done), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, "_flags"}, {30'h0, rsp_zero, rsp_neg}, 32'd0);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Add 3+4
        issue(4'd3, 4'd4, 4'b0110);
        check("add_alu_sel", 32'(alu_sel), 32'h6);
        check("add_alu_ab", {24'h0, alu_a, alu_b}, 32'h34);
        check("add_busy", 32'(cmd_ready), 32'd0);
        check("add_early", 32'(rsp_valid), 32'd0);
        tick();
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_y", 32'(rsp_y), 32'h07);
        check("add_sel", 32'(rsp_sel), 32'h6);
        check("add_ops", 32'(ops_done), 32'd1);
        check("add_ready", 32'(cmd_ready), 32'd1);
        pop1();
        check("add_popped", 32'(rsp_valid), 32'd0);
        check("add_empty_y", 32'(rsp_y), 32'h00);

        // Subtract 2-5, negative
        issue(4'd2, 4'd5, 4'b0111);
        tick();
        check("sub_y", 32'(rsp_y), 32'hFD);
        check("sub_ops", 32'(ops_done), 32'd2);
`ifdef ALU_SEQ_FLAGS_EN
        check("sub_neg", 32'(rsp_neg), 32'd1);
        check("sub_zero", 32'(rsp_zero), 32'd0);
`endif
        pop1();

        // AND with zero result
        issue(4'hA, 4'h5, 4'b1010);
        tick();
        check("and_valid", 32'(rsp_valid), 32'd1);
        check("and_y", 32'(rsp_y), 32'h00);
        check("and_sel", 32'(rsp_sel), 32'hA);
`ifdef ALU_SEQ_FLAGS_EN
        check("and_zero", 32'(rsp_zero), 32'd1);
        check("and_neg", 32'(rsp_neg), 32'd0);
`endif
        pop1();

        // Fill the FIFO; results i+1 for a=i, b=1
        for (int i = 1; i <= 4; i++) begin
            issue(4'(i), 4'd1, 4'b0110);
            tick();
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_head", 32'(rsp_y), 32'h02);
        cmd_a     = 4'd5;
        cmd_b     = 4'd1;
        cmd_sel   = 4'b0110;
        cmd_valid = 1'b1;
        tick();
        tick();
        check("full_held_a", 32'(alu_a), 32'd4);
        check("full_held_rdy", 32'(cmd_ready), 32'd0);
        check("full_ops", 32'(ops_done), 32'd7);
        pop1();
        check("full_pop_rdy", 32'(cmd_ready), 32'd1);
        check("full_pop_head", 32'(rsp_y), 32'h03);
        tick();
        check("full_acc_a", 32'(alu_a), 32'd5);
        check("full_acc_busy", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        tick();
        check("full_ops5", 32'(ops_done), 32'd8);
        for (int i = 3; i <= 6; i++) begin
            check("full_order", 32'(rsp_y), 32'(i));
            pop1();
        end
        check("full_drained", 32'(rsp_valid), 32'd0);

        // Simultaneous push and pop at count 2
        issue(4'd1, 4'd1, 4'b0110);
        tick();
        issue(4'd7, 4'd7, 4'b0110);
        tick();
        check("pp_head0", 32'(rsp_y), 32'h02);
        issue(4'd9, 4'd3, 4'b0111);
        pop1();
        check("pp_head1", 32'(rsp_y), 32'h0E);
        check("pp_ops", 32'(ops_done), 32'd11);
        check("pp_ready", 32'(cmd_ready), 32'd1);
        pop1();
        check("pp_head2", 32'(rsp_y), 32'h06);
        check("pp_sel2", 32'(rsp_sel), 32'h7);
        pop1();
        check("pp_count2", 32'(rsp_valid), 32'd0);

        // Reset while in DRIVE
        issue(4'd3, 4'd4, 4'b0110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_drive");
        tick();
        check("rst_no_result", 32'(rsp_valid), 32'd0);

        // ops_done wrap
        rsp_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            issue(4'(i), 4'(i >> 4), 4'b0110);
            tick();
        end
        check("wrap_255", 32'(ops_done), 32'd255);
        issue(4'd1, 4'd2, 4'b0110);
        tick();
        check("wrap_0", 32'(ops_done), 32'd0);
        check("wrap_last_y", 32'(rsp_y), 32'h03);
        rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential front-end for the 4-bit combinational ALU. Accepts operation commands over a valid/ready handshake, drives the ALU operand and select lines from registers, samples the ALU's 8-bit signed result one cycle later, and queues results in a small FIFO for a downstream consumer. It is the initiator/collector side of the ALU interface: it produces `a`/`b`/`sel` and consumes `y`.

## Interface
- `DEPTH`, 4, result FIFO entries; power of two, ≥ 2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_a` input 4: operand A.
- `cmd_b` input 4: operand B.
- `cmd_sel` input 4: ALU opcode; bit 3 selects logic (1) or arithmetic (0).
- `alu_a` output 4: registered operand A to ALU.
- `alu_b` output 4: registered operand B to ALU.
- `alu_sel` output 4: registered opcode to ALU.
- `alu_y` input 8: signed ALU result, combinational from `alu_a`/`alu_b`/`alu_sel`.
- `rsp_valid` output 1: FIFO non-empty.
- `rsp_ready` input 1: consumer pops head when `rsp_valid && rsp_ready`.
- `rsp_y` output 8: head result; 8'h00 when empty.
- `rsp_sel` output 4: opcode that produced head result; 4'h0 when empty.
- `ops_done` output 8: count of results written to FIFO, wraps 255→0.
- `rsp_zero`, `rsp_neg` output 1 each: present only with `ALU_SEQ_FLAGS_EN`.

## Operation
- FSM states: IDLE, DRIVE.
- IDLE: `cmd_ready = (count < DEPTH)`. On accept, register `cmd_a`/`cmd_b`/`cmd_sel` into `alu_a`/`alu_b`/`alu_sel`; go to DRIVE.
- DRIVE: `cmd_ready = 0`. At the next edge, push {`alu_sel`, `alu_y`} into the FIFO, increment `ops_done`, and return to IDLE.
- Operand registers hold their last value in IDLE; they are not cleared after capture.
- The result is stored exactly as the 8-bit signed `alu_y`, with no extension or truncation.
- FIFO: read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. Output is show-ahead.
- Simultaneous push and pop: both occur and the count is unchanged. This is legal when full only if a pop occurs. Push never occurs while full because IDLE gates acceptance on count.
- Pop while empty is ignored.
- Reset mid-operation: an in-flight DRIVE result is discarded. All FIFO contents are lost.

## Timing
- Reset values: `cmd_ready` 1 after reset (IDLE, empty). `alu_a`, `alu_b`, `alu_sel` are 0. `rsp_valid` is 0. `rsp_y` is 8'h00. `rsp_sel` is 4'h0. `ops_done` is 0. Flags are 0.
- Accept at edge k: `alu_*` are valid after edge k. The result is written at edge k+1.
- With an empty FIFO, `rsp_valid` rises after edge k+1. Command-to-response latency is 2 cycles.
- Throughput: one command per 2 cycles maximum. `cmd_ready` is low for the cycle after each accept.
- `alu_y` must settle within one cycle of `alu_*` changing.
- `cmd_ready` depends only on state and count, never on `cmd_valid`.
- `rsp_valid` depends only on count.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined:
  - Each FIFO entry additionally stores `rsp_zero` (result == 0) and `rsp_neg` (result bit 7), computed from `alu_y` at capture.
  - Both flags are output alongside `rsp_y`. Both are 0 when empty.
- Undefined: the flag ports and flag storage do not exist. All other behaviour is identical.

## Test plan
Bench connects `alu_*`/`alu_y` to the team's 4-bit ALU.
- Add: `cmd_a`=3, `cmd_b`=4, `cmd_sel`=4'b0110 accepted at edge k → `alu_sel`=4'b0110 after edge k; `rsp_valid`=1 after edge k+1, `rsp_y`=8'h07, `ops_done`=1.
- Subtract, negative: `cmd_a`=2, `cmd_b`=5, `cmd_sel`=4'b0111 → `rsp_y`=8'hFD. With `ALU_SEQ_FLAGS_EN`, `rsp_neg`=1 and `rsp_zero`=0.
- Logic / zero result: `cmd_a`=4'hA, `cmd_b`=4'h5, `cmd_sel`=4'b1010 (AND) → `rsp_y`=8'h00. With flags, `rsp_zero`=1.
- Full with default DEPTH=4 and `rsp_ready`=0:
  - Issue 5 back-to-back commands.
  - After the 4th capture, `cmd_ready`=0 and the 5th command is held.
  - Raise `rsp_ready` for one cycle → one pop, `cmd_ready`=1, and the 5th command is accepted.
  - Results emerge in issue order.
- Simultaneous push/pop with count=2: count stays 2 and `rsp_y` advances to the next entry. Also drive 256 commands and check that `ops_done` wraps to 0.
- Reset in DRIVE: assert `rst` in the cycle after accept → no result appears, and all outputs return to reset values on the next edge.
